// File: rtl/period_meter.sv
// period_meter: measures period and high time of a slow asynchronous
// square wave in clk cycles, with valid strobe, lock and timeout.
module period_meter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TIMEOUT = 100_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             sig_in,
  input  logic             clear,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             valid,
  output logic             locked,
  output logic             timeout
);

  localparam logic [WIDTH-1:0] TMO = WIDTH'(TIMEOUT);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    LOCKD
  } state_e;

  state_e state_q;

  logic s1_q;
  logic s2_q;
  logic s3_q;
  logic rise;
  logic fall;

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] hlatch_q;
  logic [WIDTH-1:0] hlatch_d;
  logic [WIDTH-1:0] period_q;
  logic [WIDTH-1:0] high_q;
  logic             valid_q;
  logic             locked_q;
  logic             timeout_q;

  logic cnt_max;
  logic do_clr;
  logic do_arm;
  logic do_meas;
  logic do_tmo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise    = s2_q & ~s3_q;
  assign fall    = ~s2_q & s3_q;
  assign cnt_max = (cnt_q == TMO);

  // Mutually exclusive decode of the prioritised transition rules.
  assign do_clr  = clear;
  assign do_arm  = ~clear & rise & (state_q == IDLE);
  assign do_meas = ~clear & rise & (state_q != IDLE);
  assign do_tmo  = ~clear & ~rise & cnt_max;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (rise) begin
      cnt_d = ONE;
    end else if (!cnt_max) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_comb begin
    hlatch_d = hlatch_q;
    if (clear) begin
      hlatch_d = '0;
    end else if (fall) begin
      hlatch_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      hlatch_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      hlatch_q <= hlatch_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      locked_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      unique case (1'b1)
        do_clr: begin
          state_q   <= IDLE;
          period_q  <= '0;
          high_q    <= '0;
          valid_q   <= 1'b0;
          locked_q  <= 1'b0;
          timeout_q <= 1'b0;
        end
        do_arm: begin
          state_q   <= ARMED;
          valid_q   <= 1'b0;
          timeout_q <= 1'b0;
        end
        do_meas: begin
          state_q   <= LOCKD;
          period_q  <= cnt_q;
          high_q    <= hlatch_q;
          valid_q   <= 1'b1;
          locked_q  <= 1'b1;
          timeout_q <= 1'b0;
        end
        do_tmo: begin
          state_q   <= IDLE;
          valid_q   <= 1'b0;
          locked_q  <= 1'b0;
          timeout_q <= 1'b1;
        end
        default: begin
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign period    = period_q;
  assign high_time = high_q;
  assign valid     = valid_q;
  assign locked    = locked_q;
  assign timeout   = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// tb_period_meter: randomized and directed checks of period_meter
// against an edge-time arithmetic reference model.
module tb_period_meter;

  localparam int W   = 16;
  localparam int TMO = 64;
  localparam int VW  = 2 * W + 3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         sig_in;
  logic         clear;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         valid;
  logic         locked;
  logic         timeout;

  period_meter #(
    .WIDTH  (W),
    .TIMEOUT(TMO)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sig_in   (sig_in),
    .clear    (clear),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .locked   (locked),
    .timeout  (timeout)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model: time-since-last-rise arithmetic on edge indices.
  longint       edge_n  = 0;
  longint       ref_n   = 0;
  bit           dly [3] = '{default: 0};
  logic [W-1:0] m_per   = '0;
  logic [W-1:0] m_ht    = '0;
  logic [W-1:0] m_hl    = '0;
  logic         m_v     = 1'b0;
  logic         m_lk    = 1'b0;
  logic         m_to    = 1'b0;
  int           m_rises = 0;

  // Observation log filled each cycle.
  int           n_bad;
  logic [VW-1:0] bad_got;
  logic [VW-1:0] bad_want;
  longint       bad_edge;
  int           n_valid;
  int           n_unlocked;
  int           n_to;
  logic [W-1:0] last_per;
  logic [W-1:0] last_ht;
  longint       last_valid_edge = 0;
  longint       val_gap;
  longint       to_edge;
  logic         prev_to = 1'b0;

  function automatic logic [VW-1:0] dut_vec();
    return {valid, locked, timeout, period, high_time};
  endfunction

  function automatic logic [VW-1:0] mdl_vec();
    return {m_v, m_lk, m_to, m_per, m_ht};
  endfunction

  task automatic model_step();
    longint c;
    bit r;
    bit f;
    edge_n++;
    if (!rst_n) begin
      dly     = '{default: 0};
      m_per   = '0;
      m_ht    = '0;
      m_hl    = '0;
      m_v     = 1'b0;
      m_lk    = 1'b0;
      m_to    = 1'b0;
      m_rises = 0;
      ref_n   = edge_n + 1;
      return;
    end
    c = edge_n - ref_n;
    if (c > TMO) c = TMO;
    // Detected level lags sig_in by two samples; edge by comparing to three.
    r = dly[1] & ~dly[2];
    f = ~dly[1] & dly[2];
    dly[2] = dly[1];
    dly[1] = dly[0];
    dly[0] = sig_in;
    if (clear) begin
      m_per   = '0;
      m_ht    = '0;
      m_hl    = '0;
      m_v     = 1'b0;
      m_lk    = 1'b0;
      m_to    = 1'b0;
      m_rises = 0;
      ref_n   = edge_n + 1;
      return;
    end
    m_v = 1'b0;
    if (r) begin
      ref_n = edge_n;
      m_to  = 1'b0;
      if (m_rises > 0) begin
        m_per = W'(c);
        m_ht  = m_hl;
        m_v   = 1'b1;
        m_lk  = 1'b1;
      end
      m_rises++;
    end else if (c == TMO) begin
      m_to    = 1'b1;
      m_lk    = 1'b0;
      m_rises = 0;
    end
    if (f) m_hl = W'(c);
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    @(negedge clk);
    if (dut_vec() !== mdl_vec()) begin
      if (n_bad == 0) begin
        bad_got  = dut_vec();
        bad_want = mdl_vec();
        bad_edge = edge_n;
      end
      n_bad++;
    end
    if (valid === 1'b1) begin
      n_valid++;
      last_per        = period;
      last_ht         = high_time;
      val_gap         = edge_n - last_valid_edge;
      last_valid_edge = edge_n;
    end
    if (locked !== 1'b1) n_unlocked++;
    if (timeout === 1'b1) n_to++;
    if (timeout === 1'b1 && prev_to !== 1'b1) to_edge = edge_n;
    prev_to = timeout;
  endtask

  task automatic wave(input int hi, input int lo);
    sig_in = 1'b1;
    repeat (hi) cyc();
    sig_in = 1'b0;
    repeat (lo) cyc();
  endtask

  task automatic clear_log();
    n_bad      = 0;
    n_valid    = 0;
    n_unlocked = 0;
    n_to       = 0;
    to_edge    = -1;
  endtask

  task automatic test_reset();
    clear_log();
    rst_n  = 1'b0;
    clear  = 1'b0;
    sig_in = 1'b0;
    for (int i = 0; i < 12; i++) begin
      sig_in = 1'($urandom_range(0, 1));
      cyc();
      n_total++;
      if ({valid, locked, timeout, period, high_time} !== '0)
        $display("FAIL reset_hold cyc %0d: got %h want 0", i,
                 {valid, locked, timeout, period, high_time});
      else n_pass++;
    end
    sig_in = 1'b0;
    rst_n  = 1'b1;
    repeat (3) cyc();
    wave(5, 5);
    n_total++;
    if (n_valid !== 0)
      $display("FAIL reset_first_rise: valids %0d want 0", n_valid);
    else n_pass++;
    wave(5, 5);
    n_total++;
    if (n_valid !== 1 || last_per !== W'(10) || last_ht !== W'(5))
      $display("FAIL reset_second_rise: valids %0d per %0d ht %0d want 1/10/5",
               n_valid, last_per, last_ht);
    else n_pass++;
    n_total++;
    if (n_bad !== 0)
      $display("FAIL reset_model: %0d bad, edge %0d got %h want %h",
               n_bad, bad_edge, bad_got, bad_want);
    else n_pass++;
  endtask

  task automatic test_square();
    clear_log();
    repeat (6) wave(5, 5);
    n_total++;
    if (n_valid !== 6 || val_gap !== 10)
      $display("FAIL square_rate: valids %0d gap %0d want 6/10", n_valid, val_gap);
    else n_pass++;
    n_total++;
    if (last_per !== W'(10) || last_ht !== W'(5) || locked !== 1'b1)
      $display("FAIL square_vals: per %0d ht %0d lock %b want 10/5/1",
               last_per, last_ht, locked);
    else n_pass++;
    n_total++;
    if (n_bad !== 0)
      $display("FAIL square_model: %0d bad, edge %0d got %h want %h",
               n_bad, bad_edge, bad_got, bad_want);
    else n_pass++;
  endtask

  task automatic test_duty();
    clear_log();
    repeat (4) wave(3, 7);
    n_total++;
    if (last_per !== W'(10) || last_ht !== W'(3))
      $display("FAIL duty_vals: per %0d ht %0d want 10/3", last_per, last_ht);
    else n_pass++;
    n_total++;
    if (n_unlocked !== 0)
      $display("FAIL duty_lock: unlocked cycles %0d want 0", n_unlocked);
    else n_pass++;
    n_total++;
    if (n_bad !== 0)
      $display("FAIL duty_model: %0d bad, edge %0d got %h want %h",
               n_bad, bad_edge, bad_got, bad_want);
    else n_pass++;
  endtask

  task automatic test_timeout();
    clear_log();
    sig_in = 1'b0;
    repeat (80) cyc();
    n_total++;
    if (to_edge - last_valid_edge !== longint'(TMO))
      $display("FAIL timeout_delay: got %0d want %0d",
               to_edge - last_valid_edge, TMO);
    else n_pass++;
    n_total++;
    if (timeout !== 1'b1 || locked !== 1'b0 ||
        period !== W'(10) || high_time !== W'(3))
      $display("FAIL timeout_state: to %b lk %b per %0d ht %0d want 1/0/10/3",
               timeout, locked, period, high_time);
    else n_pass++;
    n_valid = 0;
    wave(5, 5);
    n_total++;
    if (timeout !== 1'b0 || n_valid !== 0)
      $display("FAIL timeout_restart1: to %b valids %0d want 0/0",
               timeout, n_valid);
    else n_pass++;
    wave(5, 5);
    n_total++;
    if (n_valid !== 1 || locked !== 1'b1)
      $display("FAIL timeout_restart2: valids %0d lk %b want 1/1",
               n_valid, locked);
    else n_pass++;
    n_total++;
    if (n_bad !== 0)
      $display("FAIL timeout_model: %0d bad, edge %0d got %h want %h",
               n_bad, bad_edge, bad_got, bad_want);
    else n_pass++;
  endtask

  task automatic test_exact_timeout();
    clear_log();
    repeat (4) wave(32, 32);
    n_total++;
    if (n_valid !== 4 || last_per !== W'(TMO) || last_ht !== W'(32))
      $display("FAIL exact_vals: valids %0d per %0d ht %0d want 4/64/32",
               n_valid, last_per, last_ht);
    else n_pass++;
    n_total++;
    if (n_to !== 0 || n_unlocked !== 0)
      $display("FAIL exact_flags: timeout cycles %0d unlocked %0d want 0/0",
               n_to, n_unlocked);
    else n_pass++;
    n_total++;
    if (n_bad !== 0)
      $display("FAIL exact_model: %0d bad, edge %0d got %h want %h",
               n_bad, bad_edge, bad_got, bad_want);
    else n_pass++;
  endtask

  task automatic test_clear();
    int k;
    clear_log();
    repeat (2) wave(5, 5);
    sig_in = 1'b1;
    k = 0;
    for (int i = 0; i < 5; i++) begin
      if (clear === 1'b1) break;
      clear = dly[1] & ~dly[2];
      cyc();
      k++;
    end
    clear = 1'b0;
    n_total++;
    if ({valid, locked, timeout, period, high_time} !== '0)
      $display("FAIL clear_zero: got %h want 0",
               {valid, locked, timeout, period, high_time});
    else n_pass++;
    repeat (5 - k) cyc();
    sig_in = 1'b0;
    repeat (5) cyc();
    n_valid = 0;
    wave(5, 5);
    n_total++;
    if (n_valid !== 0)
      $display("FAIL clear_one_rise: valids %0d want 0", n_valid);
    else n_pass++;
    wave(5, 5);
    n_total++;
    if (n_valid !== 1 || last_per !== W'(10) || last_ht !== W'(5))
      $display("FAIL clear_two_rise: valids %0d per %0d ht %0d want 1/10/5",
               n_valid, last_per, last_ht);
    else n_pass++;
    n_total++;
    if (n_bad !== 0)
      $display("FAIL clear_model: %0d bad, edge %0d got %h want %h",
               n_bad, bad_edge, bad_got, bad_want);
    else n_pass++;
  endtask

  task automatic test_random();
    int hi;
    int lo;
    clear_log();
    for (int it = 0; it < 40; it++) begin
      if (it == 20) begin
        rst_n = 1'b0;
        repeat (3) cyc();
        rst_n = 1'b1;
      end
      hi = $urandom_range(1, 20);
      lo = (it % 9 == 8) ? $urandom_range(60, 90) : $urandom_range(1, 20);
      sig_in = 1'b1;
      for (int i = 0; i < hi; i++) begin
        clear = ($urandom_range(0, 59) == 0);
        cyc();
      end
      sig_in = 1'b0;
      for (int i = 0; i < lo; i++) begin
        clear = ($urandom_range(0, 59) == 0);
        cyc();
      end
      clear = 1'b0;
    end
    n_total++;
    if (n_bad !== 0)
      $display("FAIL random_model: %0d bad, edge %0d got %h want %h",
               n_bad, bad_edge, bad_got, bad_want);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_square();
    test_duty();
    test_timeout();
    test_exact_timeout();
    test_clear();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got %0d/%0d",
             n_pass, n_total);
    $fatal(1);
  end

endmodule
